// File: rtl/de_selector14_pkg.sv
// Shared types and helpers for the de_selector14 round-robin dispatcher.
package de_selector14_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // First requesting channel after last, wrapping; last itself is checked last.
  function automatic logic [CH_W-1:0] rr_pick(
    input logic [CH_W-1:0]   last,
    input logic [NUM_CH-1:0] req
  );
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] pick;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + CH_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/de_selector14.sv
// 1-to-4 demultiplexer: routes the valid bit and a DW-wide data word
// to the output selected by {iS1,iS0}; everything is 0 while iEn is low.
module de_selector14 #(
  parameter int DW = 1
) (
  input  logic          iC,
  input  logic          iEn,
  input  logic          iS1,
  input  logic          iS0,
  input  logic [DW-1:0] iD,
  output logic          oZ0,
  output logic          oZ1,
  output logic          oZ2,
  output logic          oZ3,
  output logic [DW-1:0] oD0,
  output logic [DW-1:0] oD1,
  output logic [DW-1:0] oD2,
  output logic [DW-1:0] oD3
);

  logic [3:0] hot;

  always_comb begin
    hot = 4'b0000;
    if (iEn) hot = 4'b0001 << {iS1, iS0};
  end

  assign oZ0 = iC & hot[0];
  assign oZ1 = iC & hot[1];
  assign oZ2 = iC & hot[2];
  assign oZ3 = iC & hot[3];

  assign oD0 = hot[0] ? iD : '0;
  assign oD1 = hot[1] ? iD : '0;
  assign oD2 = hot[2] ? iD : '0;
  assign oD3 = hot[3] ? iD : '0;

endmodule

// File: rtl/de_selector14_ctrl.sv
// Round-robin burst dispatcher driving de_selector14.
// Define DESEL_CNT_EN to add per-channel saturating beat counters (oBeatCnt).
module de_selector14_ctrl
  import de_selector14_pkg::*;
#(
  parameter int DW        = 1,
  parameter int BURST_LEN = 4,
  parameter int STALL_MAX = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DW-1:0]     iData,
  input  logic [NUM_CH-1:0] iReady,
  output logic [NUM_CH-1:0] oValid,
  output logic [DW-1:0]     oZ0,
  output logic [DW-1:0]     oZ1,
  output logic [DW-1:0]     oZ2,
  output logic [DW-1:0]     oZ3,
  output logic              oS1,
  output logic              oS0,
  output logic              oBusy
`ifdef DESEL_CNT_EN
  ,
  output logic [31:0]       oBeatCnt
`endif
);

  state_t          state, state_nx;
  logic [CH_W-1:0] gnt, gnt_nx;
  logic [CH_W-1:0] last, last_nx;
  logic [4:0]      cnt, cnt_nx;
  logic [7:0]      stall, stall_nx;

  logic xfer, rdy, fire, stall_hit;

  assign xfer      = (state == ST_XFER);
  assign rdy       = xfer & iReady[gnt];
  assign fire      = iValid & rdy;
  assign stall_hit = xfer & iValid & ~iReady[gnt];

  assign oReady     = rdy;
  assign oBusy      = xfer;
  assign {oS1, oS0} = gnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      last  <= 2'd3;
      cnt   <= '0;
      stall <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      stall <= stall_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    cnt_nx   = cnt;
    stall_nx = stall;
    unique case (state)
      ST_IDLE: begin
        if (iValid && (|iReady)) begin
          gnt_nx   = rr_pick(last, iReady);
          last_nx  = gnt_nx;
          cnt_nx   = '0;
          stall_nx = '0;
          state_nx = ST_XFER;
        end
      end
      ST_XFER: begin
        unique case (1'b1)
          fire: begin
            cnt_nx   = cnt + 5'd1;
            stall_nx = '0;
            if (cnt == 5'(BURST_LEN - 1)) state_nx = ST_IDLE;
          end
          stall_hit: begin
            stall_nx = stall + 8'd1;
            if (stall_nx == 8'(STALL_MAX)) state_nx = ST_IDLE;
          end
          default: ;
        endcase
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  de_selector14 #(
    .DW(DW)
  ) u_demux (
    .iC  (fire),
    .iEn (xfer),
    .iS1 (gnt[1]),
    .iS0 (gnt[0]),
    .iD  (iData),
    .oZ0 (oValid[0]),
    .oZ1 (oValid[1]),
    .oZ2 (oValid[2]),
    .oZ3 (oValid[3]),
    .oD0 (oZ0),
    .oD1 (oZ1),
    .oD2 (oZ2),
    .oD3 (oZ3)
  );

`ifdef DESEL_CNT_EN
  logic [7:0] bcnt [NUM_CH];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < NUM_CH; k++) bcnt[k] <= '0;
    end else if (fire && (bcnt[gnt] != 8'hFF)) begin
      bcnt[gnt] <= bcnt[gnt] + 8'd1;
    end
  end

  assign oBeatCnt = {bcnt[3], bcnt[2], bcnt[1], bcnt[0]};
`endif

endmodule

// File: tb/tb_de_selector14_ctrl.sv
// Randomized scoreboard bench for de_selector14_ctrl.
module tb_de_selector14_ctrl;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [3:0]    ready = 4'b0000;

  logic          o_ready;
  logic [3:0]    o_valid;
  logic [DW-1:0] z0, z1, z2, z3;
  logic          s1, s0, busy;
`ifdef DESEL_CNT_EN
  logic [31:0]   beat_cnt;
`endif

  always #5 clk = ~clk;

  de_selector14_ctrl #(
    .DW(DW), .BURST_LEN(BL), .STALL_MAX(SM)
  ) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid), .oReady(o_ready),
    .iData(data), .iReady(ready), .oValid(o_valid),
    .oZ0(z0), .oZ1(z1), .oZ2(z2), .oZ3(z3),
    .oS1(s1), .oS0(s0), .oBusy(busy)
`ifdef DESEL_CNT_EN
    , .oBeatCnt(beat_cnt)
`endif
  );

  typedef struct packed {
    logic          rdy;
    logic [3:0]    vld;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [1:0]    sel;
    logic          bsy;
    logic [31:0]   bc;
  } obs_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
  } beat_t;

  obs_t  exp_q[$];
  beat_t beat_q[$];
  int    checks = 0;
  int    failures = 0;

  // Reference: granted channel, beats in this burst, stall run, per-channel totals
  bit m_busy;
  int m_gnt, m_last, m_cnt, m_stall;
  int m_bc[4];

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_last = 3; m_cnt = 0; m_stall = 0;
    for (int k = 0; k < 4; k++) m_bc[k] = 0;
  endtask

  // Advance the model over one clock edge using the inputs held at that edge.
  task automatic model_step();
    if (!m_busy) begin
      if (valid && ready != 4'b0000) begin
        for (int i = 1; i <= 4; i++) begin
          int c;
          c = (m_last + i) % 4;
          if (ready[c]) begin
            m_gnt = c;
            break;
          end
        end
        m_last = m_gnt; m_cnt = 0; m_stall = 0; m_busy = 1;
      end
    end else if (valid && ready[m_gnt]) begin
      m_cnt++;
      m_stall = 0;
      if (m_bc[m_gnt] < 255) m_bc[m_gnt]++;
      if (m_cnt == BL) m_busy = 0;
    end else if (valid) begin
      m_stall++;
      if (m_stall == SM) m_busy = 0;
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '0;
    o.rdy = o_ready; o.vld = o_valid;
    o.d0 = z0; o.d1 = z1; o.d2 = z2; o.d3 = z3;
    o.sel = {s1, s0}; o.bsy = busy;
`ifdef DESEL_CNT_EN
    o.bc = beat_cnt;
`endif
    return o;
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    e = '0;
    e.sel = 2'(m_gnt);
    if (m_busy) begin
      e.bsy = 1'b1;
      e.rdy = ready[m_gnt];
      if (valid && e.rdy) e.vld[m_gnt] = 1'b1;
      case (m_gnt)
        0: e.d0 = data;
        1: e.d1 = data;
        2: e.d2 = data;
        default: e.d3 = data;
      endcase
    end
`ifdef DESEL_CNT_EN
    e.bc = {8'(m_bc[3]), 8'(m_bc[2]), 8'(m_bc[1]), 8'(m_bc[0])};
`endif
    return e;
  endfunction

  task automatic drive(input logic v, input logic [3:0] r);
    obs_t  e;
    beat_t b;
    @(posedge clk);
    model_step();
    #1;
    valid = v; ready = r; data = DW'($urandom);
    e = expect_now();
    exp_q.push_back(e);
    if (e.vld != 4'b0000) begin
      b.ch = m_gnt; b.d = data;
      beat_q.push_back(b);
    end
  endtask

  task automatic check_zero(input string name);
    obs_t a;
    a = observe();
    checks++;
    if (a !== '0) begin
      failures++;
      $display("FAIL %s: got %h want 0", name, a);
    end
  endtask

  // Monitor: compare every cycle the stimulus predicted, and every presented beat.
  obs_t  mon_e, mon_a;
  beat_t mon_b;
  int    mon_ch;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = observe();
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL cycle t=%0t: got %h want %h", $time, mon_a, mon_e);
      end
    end
    if (rst_n && o_valid != 4'b0000) begin
      checks++;
      if (beat_q.size() == 0) begin
        failures++;
        $display("FAIL beat t=%0t: got valid %b want none", $time, o_valid);
      end else begin
        mon_b = beat_q.pop_front();
        mon_ch = 0;
        for (int k = 3; k >= 0; k--) if (o_valid[k]) mon_ch = k;
        mon_a = observe();
        if (mon_ch != mon_b.ch ||
            (mon_ch == 0 && mon_a.d0 != mon_b.d) ||
            (mon_ch == 1 && mon_a.d1 != mon_b.d) ||
            (mon_ch == 2 && mon_a.d2 != mon_b.d) ||
            (mon_ch == 3 && mon_a.d3 != mon_b.d)) begin
          failures++;
          $display("FAIL beat t=%0t: got ch%0d want ch%0d/%h",
                   $time, mon_ch, mon_b.ch, mon_b.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    model_reset();
    // Reset held with random inputs: everything stays 0
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      valid = 1'($urandom); ready = 4'($urandom); data = DW'($urandom);
      #2;
      check_zero("reset_hold");
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 4'($urandom));
    for (int i = 0; i < 40; i++) drive(1'b1, 4'b1111);
    for (int i = 0; i < 40; i++) drive(1'b1, 4'b0100);
    for (int i = 0; i < 200; i++) begin
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 11) == 0);
      drive(1'b1, r);
    end
    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 4'($urandom));

    // Reset in the middle of a ch2 burst, after two beats
    guard = 0;
    do begin
      drive(1'b1, 4'b0100);
      guard++;
    end while (!(m_busy && m_gnt == 2 && m_cnt == 2) && guard < 50);
    checks++;
    if (guard >= 50) begin
      failures++;
      $display("FAIL mid_reset_setup: got no ch2 beat 2 want within 50 cycles");
    end
    #2;
    exp_q.delete();
    beat_q.delete();
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b1, 4'b1111);

    for (int i = 0; i < 400; i++) drive(1'b1, 4'b0001);
    for (int i = 0; i < 20; i++) drive(1'($urandom), 4'($urandom));
    drive(1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    checks++;
    if (beat_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats %0d cycles pending want 0",
               beat_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de_selector14_ctrl.md
Name: de_selector14_ctrl

Overview:
Round-robin dispatcher that sequences the 1-to-4 demultiplexer `de_selector14`. It takes a single valid/ready input stream and hands it to four consumers in turn. Each consumer keeps its grant for up to BURST_LEN beats. The block drives the select lines (iS1/iS0 equivalent) and per-channel valids, and instantiates the demux as its routing datapath.

Parameters:
- DW, 1, data width of iData and each oZk.
- BURST_LEN, 4, beats per grant before re-arbitration (legal range 1..16).
- STALL_MAX, 8, consecutive cycles the granted consumer may hold iReady low before its grant is revoked (legal range 1..255).

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  reset, asynchronous, active-low.
- iValid  in  1  upstream beat valid.
- oReady  out  1  upstream ready; a beat transfers when iValid and oReady are both 1.
- iData  in  DW  upstream beat.
- iReady  in  4  per-consumer ready; bit k belongs to channel k.
- oValid  out  4  one-hot per-consumer valid.
- oZ0, oZ1, oZ2, oZ3  out  DW  routed data for channels 0..3.
- oS1, oS0  out  1  current select; {oS1,oS0} = granted channel index.
- oBusy  out  1  high while in XFER.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous, active-low on iRst_n.
- Reset values: state=IDLE, gnt=0, last=3, beat cnt=0, stall cnt=0, all outputs 0.
- FSM states: IDLE, XFER.
- IDLE transitions:
  - If iValid=1 and iReady!=0: pick the first ready channel scanning last+1, last+2, ... (mod 4).
  - Register that channel into gnt and last, clear cnt and stall, go to XFER.
  - No beat transfers in IDLE, so arbitration costs exactly 1 cycle.
  - Otherwise stay in IDLE.
- XFER routing:
  - Routing is combinational, zero latency: oReady = iReady[gnt], oValid[gnt] = iValid & iReady[gnt], oZ{gnt} = iData.
  - Non-granted oValid bits and oZ outputs are 0.
  - Select lines are registered and stable for the whole grant.
- XFER beat counting:
  - On each transfer: cnt++ and stall cleared.
  - The transfer with cnt==BURST_LEN-1 ends the grant: go to IDLE.
- XFER idle and stall cycles:
  - iValid=0 with iReady[gnt]=1: hold the grant; cnt and stall are unchanged.
  - iValid=1 with iReady[gnt]=0: stall++.
  - When stall reaches STALL_MAX: go to IDLE. Beats already delivered count; the remainder of the burst is forfeited.
- Boundary cases:
  - BURST_LEN=1: each beat is followed by an IDLE arbitration cycle.
  - Only one channel ready: that channel is re-granted every arbitration.
  - iReady bits of non-granted channels are ignored during XFER.
  - Reset asserted mid-burst clears everything immediately, with no partial-beat output.
  - last wraps 3 -> 0.

Optional Feature:
- DESEL_CNT_EN defined:
  - Adds output oBeatCnt (32 bits); bits [8k+7:8k] count beats delivered to channel k.
  - Counters saturate at 255 and reset to 0.
- DESEL_CNT_EN not defined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header de_selector14_pkg:
  - NUM_CH=4, CH_W=2.
  - State encodings ST_IDLE=1'b0, ST_XFER=1'b1.
- Sub-module: the existing `de_selector14`, instantiated for routing.
  - iC <- iValid & oReady for the valid path.
  - DW-wide data uses the same one-hot select.
- Controller logic (FSM, arbiter, counters) lives in de_selector14_ctrl.

Test Plan (BURST_LEN=4, STALL_MAX=8 unless noted):
- Reset: hold iRst_n=0 with random inputs -> all outputs 0. Release with iValid=0 -> remains IDLE, oBusy=0, {oS1,oS0}=00.
- Full rotation: iReady=4'b1111, iValid=1 continuously -> grants ch0, ch1, ch2, ch3, ch0. Each grant is 4 transfers plus 1 IDLE cycle (5-cycle period). {oS1,oS0} steps 00, 01, 10, 11. oValid is one-hot matching.
- Skip: iReady=4'b0100, iValid=1 -> every grant goes to ch2, oValid=4'b0100 during XFER; ch0/1/3 never see valid.
- Stall timeout: ch1 granted; 2 beats transfer, then iReady[1]=0 for 8 cycles -> IDLE after the 8th stall cycle. Next grant is ch2 if ready.
- Reset mid-burst: ch2 granted, assert iRst_n=0 after beat 2 -> outputs 0 immediately without a clock edge. After release, the first grant is ch0.
- DESEL_CNT_EN: 300 beats to ch0 only (iReady=4'b0001) -> oBeatCnt[7:0]=255, other bytes 0.
